booth_seq_mult: RTL and testbench

//  Sequential radix-4 Booth multiplier, parametrised in operand width, signed or unsigned per operation.

---
 rtl/booth_seq_mult.sv | 98 +++++++++
 tb/tb_booth_seq_mult.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/booth_seq_mult.sv
// booth_seq_mult: sequential radix-4 Booth multiplier, one digit per clock; optional accumulate via BOOTH_ACC_EN
module booth_seq_mult #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
`ifdef BOOTH_ACC_EN
    input  logic               accumulate,
`endif
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] p
);
    localparam int D  = WIDTH / 2 + 1;
    localparam int AW = 2 * WIDTH + 4;
    localparam int CW = $clog2(D + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state, state_nx;
    logic [AW-1:0]   mc, acc, pp, acc_nx;
    logic [WIDTH+2:0] mp;
    logic [CW-1:0]   cnt;
    logic            accept, last;
`ifdef BOOTH_ACC_EN
    logic            acc_mode;
`endif

    assign accept = start && state != CALC;
    assign last   = cnt == CW'(D - 1);

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // next state and handshake outputs
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = accept ? CALC : IDLE;
            CALC:    state_nx = last ? DONE : CALC;
            DONE:    state_nx = accept ? CALC : IDLE;
            default: state_nx = IDLE;
        endcase
        busy = state == CALC;
        done = state == DONE;
    end

    // Booth digit select; mc is already shifted to the current digit weight
    always_comb begin
        case (mp[2:0])
            3'b001, 3'b010: pp = mc;
            3'b011:         pp = mc << 1;
            3'b100:         pp = -(mc << 1);
            3'b101, 3'b110: pp = -mc;
            default:        pp = '0;
        endcase
        acc_nx = acc + pp;
    end

    // operand capture, digit accumulation and result write-back
    always_ff @(posedge clk) begin
        if (rst) begin
            mc  <= '0;
            mp  <= '0;
            acc <= '0;
            cnt <= '0;
            p   <= '0;
`ifdef BOOTH_ACC_EN
            acc_mode <= 1'b0;
`endif
        end else if (accept) begin
            mc  <= {{(AW-WIDTH){signed_mode & a[WIDTH-1]}}, a};
            mp  <= {{2{signed_mode & b[WIDTH-1]}}, b, 1'b0};
            acc <= '0;
            cnt <= '0;
`ifdef BOOTH_ACC_EN
            acc_mode <= accumulate;
`endif
        end else if (state == CALC) begin
            acc <= acc_nx;
            mc  <= mc << 2;
            mp  <= {{2{mp[WIDTH+2]}}, mp[WIDTH+2:2]};
            cnt <= cnt + CW'(1);
`ifdef BOOTH_ACC_EN
            if (last) p <= acc_nx[2*WIDTH-1:0] + (acc_mode ? p : '0);
`else
            if (last) p <= acc_nx[2*WIDTH-1:0];
`endif
        end
    end
endmodule

// File: tb/tb_booth_seq_mult.sv
// tb_booth_seq_mult: directed vector table plus handshake corner sequences for booth_seq_mult (WIDTH=4 and WIDTH=8)
module tb_booth_seq_mult;
    logic       clk, rst;
    logic       start, signed_mode, accumulate;
    logic [3:0] a, b;
    logic       busy, done;
    logic [7:0] p;
    logic       start8, sm8, acc8;
    logic [7:0] a8, b8;
    logic       busy8, done8;
    logic [15:0] p8;
    int vectors = 0;
    int errors = 0;

    typedef struct {
        logic       sm;
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] p;
    } vec_t;
    vec_t tv[12];

    booth_seq_mult #(.WIDTH(4)) dut (
        .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode), .a(a), .b(b),
`ifdef BOOTH_ACC_EN
        .accumulate(accumulate),
`endif
        .busy(busy), .done(done), .p(p)
    );

    booth_seq_mult #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .signed_mode(sm8), .a(a8), .b(b8),
`ifdef BOOTH_ACC_EN
        .accumulate(acc8),
`endif
        .busy(busy8), .done(done8), .p(p8)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    task automatic launch(input logic sm, input logic [3:0] x, input logic [3:0] y);
        signed_mode = sm;
        a = x;
        b = y;
        start = 1;
        @(posedge clk);
        #1 start = 0;
    endtask

    task automatic wait_done(output int lat, output int busy_cnt);
        lat = 0;
        busy_cnt = 0;
        while (!done && lat < 20) begin
            if (busy) busy_cnt++;
            @(posedge clk);
            #1 lat++;
        end
    endtask

    initial begin
        int lat, bc, dc, xi, yi;
        logic [15:0] e;
        tv[0]  = '{1'b0, 4'hF, 4'hF, 8'hE1};
        tv[1]  = '{1'b1, 4'h8, 4'h8, 8'h40};
        tv[2]  = '{1'b1, 4'h8, 4'h7, 8'hC8};
        tv[3]  = '{1'b1, 4'h7, 4'hF, 8'hF9};
        tv[4]  = '{1'b0, 4'h0, 4'h0, 8'h00};
        tv[5]  = '{1'b0, 4'hF, 4'h1, 8'h0F};
        tv[6]  = '{1'b1, 4'hF, 4'hF, 8'h01};
        tv[7]  = '{1'b0, 4'h8, 4'h8, 8'h40};
        tv[8]  = '{1'b1, 4'h3, 4'h5, 8'h0F};
        tv[9]  = '{1'b0, 4'h9, 4'h7, 8'h3F};
        tv[10] = '{1'b1, 4'h5, 4'hD, 8'hF1};
        tv[11] = '{1'b0, 4'hC, 4'hA, 8'h78};
        rst = 1; start = 0; signed_mode = 0; accumulate = 0; a = 0; b = 0;
        start8 = 0; sm8 = 0; acc8 = 0; a8 = 0; b8 = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset busy", 32'(busy), 0);
        chk("reset done", 32'(done), 0);
        chk("reset p", 32'(p), 0);
        rst = 0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 12; i++) begin
            launch(tv[i].sm, tv[i].a, tv[i].b);
            wait_done(lat, bc);
            chk($sformatf("vec%0d p", i), 32'(p), 32'(tv[i].p));
            chk($sformatf("vec%0d latency", i), lat, 3);
            chk($sformatf("vec%0d busy cycles", i), bc, 3);
            @(posedge clk);
            #1;
        end
        launch(0, 4'h5, 4'h3);
        chk("p held in calc", 32'(p), 32'h78);
        signed_mode = 1; a = 4'h2; b = 4'h2; start = 1;
        @(posedge clk);
        #1 start = 0; a = 4'hA; b = 4'h9;
        wait_done(lat, bc);
        chk("ignored restart p", 32'(p), 32'h0F);
        chk("ignored restart latency", lat, 2);
        launch(0, 4'h2, 4'h3);
        chk("b2b done drops", 32'(done), 0);
        chk("b2b p held", 32'(p), 32'h0F);
        wait_done(lat, bc);
        chk("b2b p", 32'(p), 32'h06);
        chk("b2b latency", lat, 3);
        @(posedge clk);
        #1;
        launch(1, 4'h7, 4'h7);
        @(posedge clk);
        #1 rst = 1;
        @(posedge clk);
        #1 rst = 0;
        chk("mid reset busy", 32'(busy), 0);
        chk("mid reset done", 32'(done), 0);
        chk("mid reset p", 32'(p), 0);
        dc = 0;
        repeat (8) begin
            @(posedge clk);
            #1 if (done) dc++;
        end
        chk("no done after reset", dc, 0);
`ifdef BOOTH_ACC_EN
        accumulate = 0;
        launch(0, 4'h3, 4'h5);
        wait_done(lat, bc);
        chk("acc0 3x5", 32'(p), 32'h0F);
        accumulate = 1;
        launch(0, 4'h2, 4'h2);
        wait_done(lat, bc);
        chk("acc1 2x2", 32'(p), 32'h13);
        launch(0, 4'hF, 4'hF);
        wait_done(lat, bc);
        chk("acc1 15x15 wrap", 32'(p), 32'hF4);
        accumulate = 0;
        @(posedge clk);
        #1;
`endif
        for (int i = 0; i < 1000; i++) begin
            sm8 = i[0];
            a8 = 8'($urandom);
            b8 = 8'($urandom);
            if (i == 0) begin a8 = 8'h80; b8 = 8'h80; end
            if (i == 1) begin a8 = 8'hFF; b8 = 8'hFF; end
            xi = sm8 ? int'($signed(a8)) : int'(a8);
            yi = sm8 ? int'($signed(b8)) : int'(b8);
            e = 16'(xi * yi);
            start8 = 1;
            @(posedge clk);
            #1 start8 = 0;
            lat = 0;
            while (!done8 && lat < 20) begin
                @(posedge clk);
                #1 lat++;
            end
            chk($sformatf("w8 %0d %h*%h sm%0d", i, a8, b8, sm8), 32'(p8), 32'(e));
            chk($sformatf("w8 %0d latency", i), lat, 5);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
